// File: rtl/tm1638_ctrl_pkg.sv
// rtl/tm1638_ctrl_pkg.sv - TM1638 command bytes, FSM encoding and transaction helpers
package tm1638_ctrl_pkg;

  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON    = 8'h88;
  localparam logic [7:0] CMD_DISP_OFF   = 8'h80;
  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    GAP,
    RWAIT,
    DONE
  } state_t;

  localparam logic [1:0] TXN_MODE = 2'd0;
  localparam logic [1:0] TXN_DISP = 2'd1;
  localparam logic [1:0] TXN_CTRL = 2'd2;
  localparam logic [1:0] TXN_KEYS = 2'd3;

  // Index of the final byte of each transaction (command byte is index 0).
  function automatic logic [4:0] last_byte(input logic [1:0] txn);
    case (txn)
      TXN_DISP: last_byte = 5'd16;
      TXN_KEYS: last_byte = 5'd4;
      default:  last_byte = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/tm1638_ctrl.sv
// rtl/tm1638_ctrl.sv - TM1638 frame sequencer driving an external byte serializer
// Each frame: mode cmd, display RAM burst, brightness control, key scan read.
module tm1638_ctrl
  import tm1638_ctrl_pkg::*;
#(
  parameter int STB_GAP   = 12,
  parameter int READ_WAIT = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [127:0] disp,
  input  logic [2:0]   bright,
  input  logic         disp_en,
  output logic [31:0]  keys,
  output logic         keys_valid,
  output logic         frame_done,
  output logic         stb,
  output logic         dio_oe,
  output logic         sb_latch,
  output logic [7:0]   sb_wdata,
  output logic         sb_rw,
  input  logic [7:0]   sb_rdata,
  input  logic         sb_busy
);

  state_t         r_state;
  logic [4:0]     r_byte;
  logic [1:0]     r_txn;
  logic [15:0]    r_cnt;
  logic [127:0]   r_disp;
  logic [2:0]     r_bright;
  logic           r_disp_en;
  logic [23:0]    r_kbuf;

  logic [7:0]     w_wdata;
  logic           w_rw;
  logic [3:0]     w_didx;
  logic           w_last;

  assign w_didx = 4'(r_byte - 5'd1);
  assign w_last = (r_byte == last_byte(r_txn));

  always_comb begin
    w_wdata = 8'h00;
    w_rw    = 1'b1;
    case (r_txn)
      TXN_MODE: w_wdata = CMD_WRITE_AUTO;
      TXN_DISP: w_wdata = (r_byte == 5'd0) ? CMD_ADDR0 : r_disp[{w_didx, 3'b000} +: 8];
      TXN_CTRL: w_wdata = (r_disp_en ? CMD_DISP_ON : CMD_DISP_OFF) | {5'b00000, r_bright};
      TXN_KEYS: begin
        if (r_byte == 5'd0) begin
          w_wdata = CMD_READ_KEYS;
        end else begin
          w_rw = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_byte     <= 5'd0;
      r_txn      <= 2'd0;
      r_cnt      <= 16'd0;
      r_disp     <= 128'd0;
      r_bright   <= 3'd0;
      r_disp_en  <= 1'b0;
      r_kbuf     <= 24'd0;
      keys       <= 32'd0;
      keys_valid <= 1'b0;
      frame_done <= 1'b0;
      stb        <= 1'b1;
      dio_oe     <= 1'b1;
      sb_latch   <= 1'b0;
      sb_wdata   <= 8'h00;
      sb_rw      <= 1'b1;
    end else begin
      sb_latch   <= 1'b0;
      keys_valid <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          stb    <= 1'b1;
          dio_oe <= 1'b1;
          if (run && !sb_busy) begin
            r_disp    <= disp;
            r_bright  <= bright;
            r_disp_en <= disp_en;
            r_txn     <= 2'd0;
            r_state   <= START;
          end
        end
        START: begin
          stb     <= 1'b0;
          r_byte  <= 5'd0;
          r_state <= ISSUE;
        end
        ISSUE: begin
          sb_latch <= 1'b1;
          sb_wdata <= w_wdata;
          sb_rw    <= w_rw;
          r_state  <= WAIT_HI;
        end
        WAIT_HI: r_state <= WAIT_LO;
        WAIT_LO: begin
          if (!sb_busy) begin
            if (!sb_rw) begin
              case (r_byte)
                5'd1:    r_kbuf[7:0]   <= sb_rdata;
                5'd2:    r_kbuf[15:8]  <= sb_rdata;
                5'd3:    r_kbuf[23:16] <= sb_rdata;
                default: ;
              endcase
            end
            if (r_txn == TXN_KEYS && r_byte == 5'd0) begin
              dio_oe  <= 1'b0;
              r_cnt   <= 16'(READ_WAIT - 1);
              r_byte  <= 5'd1;
              r_state <= RWAIT;
            end else if (!w_last) begin
              r_byte  <= r_byte + 5'd1;
              r_state <= ISSUE;
            end else begin
              stb     <= 1'b1;
              r_cnt   <= 16'(STB_GAP - 1);
              r_state <= GAP;
              // The last key byte is still on sb_rdata, so it goes straight into keys.
              if (r_txn == TXN_KEYS) begin
                keys       <= {sb_rdata, r_kbuf};
                keys_valid <= 1'b1;
                dio_oe     <= 1'b1;
              end
            end
          end
        end
        RWAIT: begin
          if (r_cnt == 16'd0) begin
            r_state <= ISSUE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        GAP: begin
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (!sb_busy) begin
            if (r_txn == TXN_KEYS) begin
              r_state <= DONE;
            end else begin
              r_txn   <= r_txn + 2'd1;
              r_state <= START;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          if (run) begin
            r_disp    <= disp;
            r_bright  <= bright;
            r_disp_en <= disp_en;
            r_txn     <= 2'd0;
            r_state   <= START;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tm1638_ctrl.md
TM1638_CTRL -- requirements
Module: tm1638_ctrl

Interface
REQ-001 SHALL have parameter STB_GAP, default 12: minimum clk cycles STB is held high between transactions.
REQ-002 SHALL have parameter READ_WAIT, default 12: clk cycles between the end of the read-command byte and the first read byte.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port run, input, 1: level; while high, refresh frames repeat back to back.
REQ-006 SHALL have port disp, input, 128: display RAM image; byte n is disp[8n+7:8n], written to TM1638 address n.
REQ-007 SHALL have port bright, input, 3: brightness code (pulse-width 0..7).
REQ-008 SHALL have port disp_en, input, 1: display on/off.
REQ-009 SHALL have port keys, output, 32: raw key scan; read byte k is keys[8k+7:8k].
REQ-010 SHALL have port keys_valid, output, 1: one-cycle pulse when keys updates.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each frame.
REQ-012 SHALL have port stb, output, 1: TM1638 STB, active-low.
REQ-013 SHALL have port dio_oe, output, 1: 1 means the pad drives dio_out, 0 means the pad is tristated.
REQ-014 SHALL have port sb_latch, output, 1: byte-serializer start strobe.
REQ-015 SHALL have port sb_wdata, output, 8: byte to send.
REQ-016 SHALL have port sb_rw, output, 1: 1 means write byte, 0 means read byte.
REQ-017 SHALL have port sb_rdata, input, 8: received byte.
REQ-018 SHALL have port sb_busy, input, 1: serializer busy.

Function
REQ-019 Frame sequence SHALL be:
- T1: stb low, send 0x40, stb high.
- T2: stb low, send 0xC0, then disp bytes 0..15, stb high.
- T3: stb low, send 0x88|bright if disp_en, else 0x80|bright; stb high.
- T4: stb low, send 0x42, wait READ_WAIT, read 4 bytes, stb high.
REQ-020 Byte issue SHALL follow this handshake:
- sb_latch is asserted for exactly 1 cycle.
- sb_wdata and sb_rw are held stable from the latch cycle until sb_busy falls.
- The controller waits 1 cycle for sb_busy to rise, then waits for sb_busy low.
- The next byte is latched no earlier than the cycle after sb_busy is sampled low.
REQ-021 stb SHALL fall at least 1 cycle before the first sb_latch of a transaction, and SHALL rise no earlier than 1 cycle after the final sb_busy low.
REQ-022 After each stb rise, stb SHALL stay high for STB_GAP cycles before the next fall.
REQ-023 dio_oe SHALL be 1 except during the READ_WAIT interval and the 4 read bytes of T4.
REQ-024 dio_oe SHALL return to 1 no earlier than the cycle stb rises after T4.
REQ-025 Received bytes SHALL be captured from sb_rdata in the first cycle sb_busy is low after a read byte.
REQ-026 keys SHALL be updated with all 4 captured bytes at once at T4 end, with keys_valid pulsed in that same cycle.
REQ-027 disp, bright and disp_en SHALL be snapshotted into internal registers in the cycle a frame starts; mid-frame input changes affect only the next frame.
REQ-028 FSM states SHALL be IDLE, START, ISSUE, WAIT_HI, WAIT_LO, GAP, RWAIT, DONE.
REQ-029 A byte counter (0..16) SHALL index the byte within a transaction, and a transaction counter (0..3) SHALL select T1..T4.
REQ-030 From IDLE, the FSM SHALL go to START when run is high.
REQ-031 From DONE, frame_done SHALL pulse; the FSM then goes to START if run is high, else to IDLE.
REQ-032 If run drops mid-frame, the current frame SHALL complete, including the keys update, before IDLE.
REQ-033 If sb_busy is sampled high in IDLE or GAP, the FSM SHALL wait in place and issue no latch until sb_busy is low.

Reset
REQ-034 On rst, the FSM SHALL enter IDLE and all counters SHALL be cleared.
REQ-035 Reset output values SHALL be: stb=1, dio_oe=1, sb_latch=0, sb_wdata=0, sb_rw=1, keys=0, keys_valid=0, frame_done=0.
REQ-036 Reset mid-transaction SHALL abort immediately; stb high in the first cycle of reset is sufficient.

Structure
REQ-037 A shared package SHALL hold constants CMD_WRITE_AUTO=0x40, CMD_ADDR0=0xC0, CMD_DISP_ON=0x88, CMD_DISP_OFF=0x80, CMD_READ_KEYS=0x42, and the state encoding.
REQ-038 The block SHALL be a single module with no sub-modules; the byte serializer is instantiated beside it at the top level.

Verification
REQ-039 With run=1, disp=0x0F0E..0100 (byte n = n), bright=5 and disp_en=1, one frame SHALL put 0x40 | 0xC0,0x00..0x0F | 0x8D | 0x42 on the bus, with stb low around each group and ≥12 cycles high between groups.
REQ-040 With a serializer model returning 0x11,0x22,0x44,0x88 on reads, the bench SHALL see keys=0x88442211 and exactly one keys_valid pulse.
REQ-041 With disp_en=0 and bright=2, the control byte SHALL be 0x82.
REQ-042 With dio_oe monitored during T4, dio_oe SHALL be 0 from the 0x42 busy-fall through the last read byte, and SHALL be 1 everywhere else.
REQ-043 With run dropped during byte 5 of T2, the frame SHALL complete with one frame_done pulse and the FSM SHALL then be in IDLE with stb=1.
REQ-044 With rst asserted during a read byte, the bench SHALL see the next-cycle outputs stb=1, dio_oe=1, keys=0, and a normal frame after rst is released.
